// File: rtl/altera_up_rs232_in_deserializer_pkg.sv
// Shared definitions for the RS232 receive path: receiver FSM states,
// receive FIFO geometry and the default baud timing (50 MHz / 115200 baud).
package altera_up_rs232_in_deserializer_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int FIFO_DEPTH      = 128;
  localparam int FIFO_ADDR_WIDTH = 7;

  localparam logic [8:0] DEFAULT_BAUD_TICK_COUNT      = 9'd433;
  localparam logic [8:0] DEFAULT_HALF_BAUD_TICK_COUNT = 9'd216;

endpackage

// File: rtl/altera_up_rs232_rx_fifo.sv
// Receive FIFO with first-word fall-through: rd_data_o always shows the
// oldest stored word while the FIFO is non-empty.
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   wr_en_i    write wr_data_i (accepted when not full, or when popping)
//   wr_data_i  word to store
//   rd_en_i    pop the head word (ignored while empty)
//   rd_data_o  head word, undefined while empty
//   used_o     words held, 0..DEPTH (registered)
//   full_o     FIFO holds DEPTH words
module altera_up_rs232_rx_fifo
  import altera_up_rs232_in_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]   used_o,
  output logic                  full_o
);

  // Pointers wrap by natural overflow, so DEPTH must equal 2**ADDR_WIDTH.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   used_q, used_d;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  assign full_o = (used_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty  = (used_q == '0);
  assign do_rd  = rd_en_i && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_wr  = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   used_d = used_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   used_d = used_q - (ADDR_WIDTH + 1)'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign used_o    = used_q;

endmodule

// File: rtl/altera_up_rs232_in_deserializer.sv
// RS232 receiver: synchronizes the serial line, deserializes start / data /
// stop frames and queues good words in a 128-entry show-ahead FIFO.
//   clk                  sole clock, rising edge
//   reset                asynchronous, active-low
//   serial_data_in       RS232 line, idle high, asynchronous to clk
//   receive_data_en      pop one word from the FIFO
//   fifo_read_available  words held in the FIFO, 0..128
//   received_data        head-of-FIFO word
//   frame_error          one-cycle pulse on a bad stop bit
//   overflow             one-cycle pulse when a good word is dropped (FIFO full)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle, baud counter held at 0, waiting for rx low
// RX_START | counting to start-bit mid-point; rx high there = glitch
// RX_DATA  | sampling one data bit per bit period, LSB first
// RX_STOP  | one more bit period, then judge the stop bit
module altera_up_rs232_in_deserializer
  import altera_up_rs232_in_deserializer_pkg::*;
#(
  parameter int                            BAUD_COUNTER_WIDTH   = 9,
  parameter logic [BAUD_COUNTER_WIDTH-1:0] BAUD_TICK_COUNT      =
    BAUD_COUNTER_WIDTH'(DEFAULT_BAUD_TICK_COUNT),
  parameter logic [BAUD_COUNTER_WIDTH-1:0] HALF_BAUD_TICK_COUNT =
    BAUD_COUNTER_WIDTH'(DEFAULT_HALF_BAUD_TICK_COUNT),
  parameter int                            DATA_WIDTH           = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_data_in,
  input  logic                  receive_data_en,
  output logic [7:0]            fifo_read_available,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  frame_error,
  output logic                  overflow
);

  localparam int                   BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

  logic                          rx_meta_q;
  logic                          rx_q;
  rx_state_e                     state_q, state_d;
  logic [BAUD_COUNTER_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_COUNTER_WIDTH-1:0] baud_next;
  logic                          baud_tick;
  logic [BIT_CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]         shift_q, shift_d;
  logic                          wr_q, wr_d;
  logic                          ovf_q, ovf_d;
  logic                          ferr_q, ferr_d;
  logic                          fifo_full;

  // Synchronizer resets to the idle (high) line level so a reset never
  // looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= serial_data_in;
      rx_q      <= rx_meta_q;
    end
  end

  assign baud_tick = (baud_cnt_q == BAUD_TICK_COUNT);
  assign baud_next = baud_tick ? '0 : baud_cnt_q + BAUD_COUNTER_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_d       = 1'b0;
    ovf_d      = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (baud_cnt_q == HALF_BAUD_TICK_COUNT) begin
          // Restarting the count here puts every later sample mid-bit.
          baud_cnt_d = '0;
          state_d    = rx_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_COUNTER_WIDTH'(1);
        end
      end
      RX_DATA: begin
        baud_cnt_d = baud_next;
        if (baud_tick) begin
          shift_d   = {rx_q, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        baud_cnt_d = baud_next;
        if (baud_tick) begin
          state_d = RX_IDLE;
          // Full is judged before any pop in this cycle, so a pop here
          // still leaves the word dropped.
          if (!rx_q) begin
            ferr_d = 1'b1;
          end else if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wr_q       <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  // shift_q is stable for many cycles after the stop sample, so the
  // registered write strobe can use it directly.
  altera_up_rs232_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_q),
    .wr_data_i (shift_q),
    .rd_en_i   (receive_data_en),
    .rd_data_o (received_data),
    .used_o    (fifo_read_available),
    .full_o    (fifo_full)
  );

  assign frame_error = ferr_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_altera_up_rs232_in_deserializer.sv
module tb_altera_up_rs232_in_deserializer;

  localparam int DW       = 9;
  localparam int BIT_CLKS = 16;
  localparam int EV_FERR  = 1;
  localparam int EV_OVF   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          serial_data_in = 1'b1;
  logic          receive_data_en = 1'b0;
  logic [7:0]    fifo_read_available;
  logic [DW-1:0] received_data;
  logic          frame_error;
  logic          overflow;

  altera_up_rs232_in_deserializer #(
    .BAUD_COUNTER_WIDTH   (9),
    .BAUD_TICK_COUNT      (9'd15),
    .HALF_BAUD_TICK_COUNT (9'd7),
    .DATA_WIDTH           (DW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .serial_data_in      (serial_data_in),
    .receive_data_en     (receive_data_en),
    .fifo_read_available (fifo_read_available),
    .received_data       (received_data),
    .frame_error         (frame_error),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  // Reference model: words the receiver should hold, in arrival order, and
  // the error pulses it should produce, in order.
  logic [DW-1:0] exp_data[$];
  int            exp_evt[$];
  logic [DW-1:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ev_check(input int code, input string name);
    n_tests++;
    if (exp_evt.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected pulse, no event expected", name);
    end else begin
      if (exp_evt[0] != code) begin
        n_fail++;
        $display("FAIL %s: got event %0d expected event %0d", name, code, exp_evt[0]);
      end
      void'(exp_evt.pop_front());
    end
  endtask

  // Monitor: compares every DUT pop and every error pulse with the model.
  always @(negedge clk) begin
    if (reset) begin
      if (receive_data_en && fifo_read_available != 8'd0) begin
        n_tests++;
        if (exp_data.size() == 0) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected no word", received_data);
        end else begin
          exp_w = exp_data.pop_front();
          if (received_data !== exp_w) begin
            n_fail++;
            $display("FAIL pop_data: got %0h expected %0h", received_data, exp_w);
          end
        end
      end
      if (frame_error) ev_check(EV_FERR, "frame_error");
      if (overflow)    ev_check(EV_OVF, "overflow");
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends one frame. The synchronized stop bit is sampled 170 cycles after
  // the start edge is driven; the count must move 2 cycles after that.
  task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit,
                            input bit pop_at_stop);
    int  pre;
    bit  accepted;
    pre      = exp_data.size();
    accepted = stop_bit && (pre < 128);
    if (!stop_bit)     exp_evt.push_back(EV_FERR);
    else if (!accepted) exp_evt.push_back(EV_OVF);
    else               exp_data.push_back(data);

    serial_data_in = 1'b0;
    repeat (BIT_CLKS) tick();
    for (int i = 0; i < DW; i++) begin
      serial_data_in = data[i];
      repeat (BIT_CLKS) tick();
    end
    serial_data_in = stop_bit;
    repeat (10) tick();
    if (pop_at_stop) receive_data_en = 1'b1;
    tick();
    receive_data_en = 1'b0;
    check("avail_T+1", fifo_read_available, pre - (pop_at_stop ? 1 : 0));
    tick();
    check("avail_T+2", fifo_read_available,
          pre - (pop_at_stop ? 1 : 0) + (accepted ? 1 : 0));
    repeat (4) tick();
    serial_data_in = 1'b1;
    repeat (6 + $urandom_range(0, 6)) tick();
  endtask

  task automatic pop_all();
    receive_data_en = 1'b1;
    for (int n = 0; n < 300 && fifo_read_available != 8'd0; n++) tick();
    receive_data_en = 1'b0;
    tick();
    check("drain_avail", fifo_read_available, 0);
    check("drain_model", exp_data.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] partial;

    reset = 1'b0;
    repeat (5) tick();
    check("rst_avail", fifo_read_available, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    repeat (5) tick();

    send_frame(9'h0A5, 1'b1, 1'b0);
    check("head_0A5", received_data, 9'h0A5);
    pop_all();

    for (int f = 0; f < 10; f++) begin
      d = DW'($urandom_range(0, 511));
      send_frame(d, ($urandom_range(0, 3) != 0), 1'b0);
    end
    pop_all();

    // Short low glitch: must be rejected at the start-bit mid-point.
    serial_data_in = 1'b0;
    repeat (4) tick();
    serial_data_in = 1'b1;
    repeat (30) tick();
    check("glitch_avail", fifo_read_available, 0);
    check("glitch_events", exp_evt.size(), 0);

    send_frame(DW'($urandom_range(0, 511)), 1'b0, 1'b0);
    repeat (4) tick();
    check("ferr_avail", fifo_read_available, 0);

    for (int i = 0; i < 128; i++) send_frame(DW'(i), 1'b1, 1'b0);
    check("full_avail", fifo_read_available, 128);
    send_frame(9'h155, 1'b1, 1'b0);
    check("ovf_avail", fifo_read_available, 128);
    send_frame(9'h0AA, 1'b1, 1'b1);
    check("pop_at_stop_avail", fifo_read_available, 127);
    pop_all();

    // Reset in the middle of bit 4 with one word already queued.
    send_frame(DW'($urandom_range(0, 511)), 1'b1, 1'b0);
    partial = DW'($urandom_range(0, 511));
    serial_data_in = 1'b0;
    repeat (BIT_CLKS) tick();
    for (int i = 0; i < 4; i++) begin
      serial_data_in = partial[i];
      repeat (BIT_CLKS) tick();
    end
    serial_data_in = partial[4];
    repeat (8) tick();
    reset = 1'b0;
    exp_data.delete();
    tick();
    check("midrst_avail", fifo_read_available, 0);
    check("midrst_ferr", frame_error, 0);
    check("midrst_ovf", overflow, 0);
    serial_data_in = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("postrst_avail", fifo_read_available, 0);
    send_frame(9'h1FF, 1'b1, 1'b0);
    check("head_1FF", received_data, 9'h1FF);
    pop_all();

    repeat (10) tick();
    check("events_left", exp_evt.size(), 0);
    check("words_left", exp_data.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/altera_up_rs232_in_deserializer.md
ALTERA_UP_RS232_IN_DESERIALIZER -- requirements
Module: altera_up_rs232_in_deserializer

Interface
REQ-001 SHALL have parameter BAUD_COUNTER_WIDTH, default 9, the width of the baud counter.
REQ-002 SHALL have parameter BAUD_TICK_COUNT, default 9'd433; one bit period = BAUD_TICK_COUNT+1 clk cycles.
REQ-003 SHALL have parameter HALF_BAUD_TICK_COUNT, default 9'd216, the start-bit mid-point offset.
REQ-004 SHALL have parameter DATA_WIDTH, default 9, the number of bits per frame between start and stop, LSB first.
REQ-005 SHALL have ports, clock and reset first:
  clk  input  1  sole clock, rising edge;
  reset  input  1  asynchronous, active-low;
  serial_data_in  input  1  RS232 line, idle high, asynchronous to clk;
  receive_data_en  input  1  pops one word from the FIFO;
  fifo_read_available  output  8  words held in the FIFO, 0..128;
  received_data  output  DATA_WIDTH  head-of-FIFO word (show-ahead);
  frame_error  output  1  one-cycle pulse on a bad stop bit;
  overflow  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-006 SHALL pass serial_data_in through a 2-flop synchronizer; all logic uses the synchronized value rx.
REQ-007 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-008 IDLE: SHALL clear the baud counter and enter START on the first cycle rx=0.
REQ-009 START: after HALF_BAUD_TICK_COUNT cycles, SHALL sample rx.
  rx=1: glitch; SHALL return to IDLE with no output activity.
  rx=0: SHALL clear the baud counter and enter DATA.
REQ-010 DATA: SHALL sample rx every BAUD_TICK_COUNT+1 cycles, shifting it into bit position DATA_WIDTH-1 of the shift register (right shift). After DATA_WIDTH samples it SHALL enter STOP.
REQ-011 STOP: after one more bit period, SHALL sample rx and return to IDLE on the next cycle.
  rx=1 and FIFO not full: write the shift register to the FIFO.
  rx=1 and FIFO full: pulse overflow and drop the word.
  rx=0: pulse frame_error and drop the word.
REQ-012 The baud counter SHALL count 0..BAUD_TICK_COUNT and wrap to 0; a tick fires when the count equals BAUD_TICK_COUNT.
REQ-013 The FIFO SHALL be synchronous, 128 words x DATA_WIDTH, with first-word fall-through.
REQ-014 received_data SHALL equal the oldest stored word whenever the FIFO is non-empty; it is undefined when empty.
REQ-015 A pop SHALL occur on a cycle with receive_data_en=1 and FIFO non-empty; receive_data_en while empty SHALL be ignored.
REQ-016 A simultaneous write and pop SHALL both take effect and leave the count unchanged, including when the FIFO is full. The full check for REQ-011 uses the pre-pop state, so the word is dropped.
REQ-017 fifo_read_available SHALL be registered as {full, used[6:0]} and SHALL reflect a write or pop one cycle after it occurs.
REQ-018 Read and write pointers SHALL be 7 bits and wrap 127 -> 0.
REQ-019 Latency from the stop-bit sample to fifo_read_available incrementing SHALL be 2 cycles.

Reset
REQ-020 While reset=0, the following SHALL hold:
  FSM in IDLE; synchronizer flops = 1; counters and pointers = 0;
  fifo_read_available=0, frame_error=0, overflow=0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame. After release, reception SHALL resume at the next falling edge of rx.

Structure
REQ-022 A shared package SHALL hold:
  FSM state enum;
  constants FIFO_DEPTH=128 and FIFO_ADDR_WIDTH=7;
  default baud constants 433/216.
REQ-023 The FIFO SHALL be the single sub-module, altera_up_rs232_rx_fifo, parameterized by DATA_WIDTH and depth. The FSM, baud counter and shift register SHALL be inline.

Verification (bench: BAUD_TICK_COUNT=15, HALF_BAUD_TICK_COUNT=7, 16 clks/bit)
REQ-024 Send frame 0, data 9'h0A5 LSB first, 1 -> fifo_read_available reaches 1 two cycles after the stop sample; received_data=9'h0A5; pulse receive_data_en -> count returns to 0.
REQ-025 Apply an rx low glitch of 4 cycles -> FSM returns to IDLE; no FIFO write, no frame_error, no overflow.
REQ-026 Send a frame with stop bit 0 -> frame_error pulses exactly one cycle; fifo_read_available stays 0.
REQ-027 Send 128 frames 9'h000..9'h07F with no reads -> fifo_read_available=128. A 129th frame -> overflow pulse. Pop all -> words read in order 9'h000..9'h07F.
REQ-028 With the FIFO full, assert receive_data_en on the stop-sample cycle of a good frame -> word dropped with an overflow pulse; count reads 127.
REQ-029 Assert reset during bit 4 of a frame -> outputs at reset values. A subsequent frame 9'h1FF -> received correctly.
